synch_count_ctrl: RTL and testbench

Sequencing controller for the team's 4-bit JK synchronous counter datapath. It drives the counter's count enable and clear, watches its outputs, and ends each interval at a programmed terminal value. One-shot and periodic (auto-reload) modes are supported, and completed intervals are tallied. It sits between the system control logic and the counter instance at the parent level.

---
 rtl/synch_count_ctrl_pkg.sv | 18 +
 rtl/synch_count_ctrl.sv | 127 ++++++++++++
 tb/tb_synch_count_ctrl.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/synch_count_ctrl_pkg.sv
// Shared constants for the JK counter sequencing controller:
// FSM state encodings, mode encodings and a small state-decode helper.
package synch_count_ctrl_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ARM  = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

    // An interval is in flight while arming or counting.
    function automatic logic state_is_busy(input logic [1:0] st);
        return (st == ST_ARM) || (st == ST_RUN);
    endfunction

endpackage

// File: rtl/synch_count_ctrl.sv
// Sequencing controller for the 4-bit JK synchronous counter datapath.
// Clears the counter for one cycle at the start of every interval, enables
// counting until the counter reaches the latched terminal value, then either
// stops (one-shot) or re-arms with the same limit (periodic). Each completed
// interval produces a one-cycle done pulse and bumps a wrapping tally.
module synch_count_ctrl
    import synch_count_ctrl_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int PCNT_W = 8
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              start,
    input  logic              stop,
    input  logic              pause,
    input  logic              mode,
    input  logic [WIDTH-1:0]  limit,
    input  logic [WIDTH-1:0]  cnt_q,
    output logic              cnt_en,
    output logic              cnt_clr_n,
    output logic              done,
    output logic              busy,
    output logic [PCNT_W-1:0] periods
);

    logic [1:0]        r_state;
    logic [1:0]        w_next_state;
    logic [WIDTH-1:0]  r_limit;
    logic              r_mode;
    logic              r_clr_n;
    logic              r_done;
    logic              r_busy;
    logic [PCNT_W-1:0] r_periods;

    logic              w_terminal;
    logic              w_complete;
    logic              w_latch;

    // Counter has reached the programmed terminal value while running.
    assign w_terminal = (r_state == ST_RUN) && (cnt_q == r_limit);
    // An interval only completes if neither stop nor a restart overrides it.
    assign w_complete = w_terminal & ~stop & ~start;
    // limit/mode are captured only on a start that stop does not override.
    assign w_latch    = start & ~stop;

    // Count enable is combinational so stop and pause gate it in the same cycle.
    assign cnt_en = (r_state == ST_RUN) & ~pause & ~stop & (cnt_q != r_limit);

    assign cnt_clr_n = r_clr_n;
    assign done      = r_done;
    assign busy      = r_busy;
    assign periods   = r_periods;

    // Next-state selection with priority stop > start > terminal.
    always_comb begin
        w_next_state = r_state;
        if (stop) begin
            w_next_state = ST_IDLE;
        end else if (start) begin
            w_next_state = ST_ARM;
        end else begin
            case (r_state)
                ST_IDLE: w_next_state = ST_IDLE;
                ST_ARM:  w_next_state = ST_RUN;
                ST_RUN: begin
                    if (w_terminal) begin
                        if (r_mode == MODE_PERIODIC) begin
                            w_next_state = ST_ARM;
                        end else begin
                            w_next_state = ST_DONE;
                        end
                    end else begin
                        w_next_state = ST_RUN;
                    end
                end
                ST_DONE: w_next_state = ST_DONE;
                default: w_next_state = ST_IDLE;
            endcase
        end
    end

    // State register and start-time capture of limit and mode.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            r_state <= ST_IDLE;
            r_limit <= {WIDTH{1'b0}};
            r_mode  <= MODE_ONESHOT;
        end else begin
            r_state <= w_next_state;
            if (w_latch) begin
                r_limit <= limit;
                r_mode  <= mode;
            end else begin
                r_limit <= r_limit;
                r_mode  <= r_mode;
            end
        end
    end

    // Registered datapath clear: low for exactly the ARM cycle, and held low in reset.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            r_clr_n <= 1'b0;
        end else begin
            r_clr_n <= ~(w_next_state == ST_ARM);
        end
    end

    // Registered status outputs: done pulse, busy flag and wrapping interval tally.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            r_done    <= 1'b0;
            r_busy    <= 1'b0;
            r_periods <= {PCNT_W{1'b0}};
        end else begin
            r_done <= w_complete;
            r_busy <= state_is_busy(w_next_state);
            if (w_complete) begin
                r_periods <= r_periods + {{(PCNT_W-1){1'b0}}, 1'b1};
            end else begin
                r_periods <= r_periods;
            end
        end
    end

endmodule

// File: tb/tb_synch_count_ctrl.sv
// Bench for synch_count_ctrl paired with a behavioural 4-bit synchronous
// counter (enable + async active-low clear). An interval-level reference
// model predicts every output each cycle; directed scenarios add literal
// expectations on latency and tally values.
module tb_synch_count_ctrl;

    logic       clk = 1'b0;
    logic       clear = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       pause = 1'b0;
    logic       mode = 1'b0;
    logic [3:0] limit = 4'd0;
    logic [3:0] cnt_q = 4'd0;
    logic       cnt_en;
    logic       cnt_clr_n;
    logic       done;
    logic       busy;
    logic [7:0] periods;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    synch_count_ctrl #(.WIDTH(4), .PCNT_W(8)) dut (
        .clk(clk), .clear(clear), .start(start), .stop(stop), .pause(pause),
        .mode(mode), .limit(limit), .cnt_q(cnt_q), .cnt_en(cnt_en),
        .cnt_clr_n(cnt_clr_n), .done(done), .busy(busy), .periods(periods)
    );

    // Counter datapath: counts when enabled, asynchronously cleared.
    always @(posedge clk or negedge cnt_clr_n) begin
        if (!cnt_clr_n) cnt_q <= 4'd0;
        else if (cnt_en) cnt_q <= cnt_q + 4'd1;
    end

    // Reference model at interval level: age = edges since the interval
    // began (0 = the clear cycle), cnt = value the counter should hold.
    typedef struct {
        bit in_iv;
        int age;
        int lim;
        bit md;
        int cnt;
        int per;
        bit dn;
        bit rst_clr;
    } mstate_t;

    mstate_t m;

    function automatic mstate_t model_reset();
        mstate_t r;
        r.in_iv = 0; r.age = 0; r.lim = 0; r.md = 0;
        r.cnt = 0; r.per = 0; r.dn = 0; r.rst_clr = 1;
        return r;
    endfunction

    function automatic bit model_en(mstate_t s, bit ps, bit sp);
        return s.in_iv && (s.age > 0) && !ps && !sp && (s.cnt != s.lim);
    endfunction

    function automatic mstate_t step(mstate_t s, bit st, bit sp, bit ps, bit md, int lm);
        mstate_t n = s;
        bit en;
        bit term;
        int c;
        en = model_en(s, ps, sp);
        term = s.in_iv && (s.age > 0) && (s.cnt == s.lim);
        n.dn = term && !sp && !st;
        n.rst_clr = 0;
        c = (s.cnt + int'(en)) % 16;
        if (sp) begin
            n.in_iv = 0;
        end else if (st) begin
            n.in_iv = 1; n.age = 0; n.lim = lm; n.md = md;
        end else if (term) begin
            n.per = (s.per + 1) % 256;
            if (s.md) n.age = 0;
            else n.in_iv = 0;
        end else if (s.in_iv) begin
            n.age = s.age + 1;
        end
        n.cnt = (n.in_iv && n.age == 0) ? 0 : c;
        return n;
    endfunction

    // Model advance on each edge, reset asynchronously with the DUT.
    always @(posedge clk or negedge clear) begin
        if (!clear) m <= model_reset();
        else m <= step(m, start, stop, pause, mode, int'(limit));
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    bit cmp_on = 1'b0;

    // Per-cycle comparison of all outputs against the model, away from the active edge.
    always @(negedge clk) begin
        if (cmp_on) begin
            chk("model_cnt_en", int'(cnt_en), int'(model_en(m, pause, stop)));
            chk("model_cnt_clr_n", int'(cnt_clr_n), int'(!(m.rst_clr || (m.in_iv && m.age == 0))));
            chk("model_busy", int'(busy), int'(m.in_iv));
            chk("model_done", int'(done), int'(m.dn));
            chk("model_periods", int'(periods), m.per);
            chk("model_cnt_q", int'(cnt_q), m.cnt);
        end
    end

    task automatic do_reset();
        @(posedge clk); #1 clear = 1'b0;
        @(posedge clk); #1 clear = 1'b1;
    endtask

    // Leaves the bench at #1 after the edge that sampled start.
    task automatic pulse_start(input bit md, input logic [3:0] lm);
        @(posedge clk); #1 start = 1'b1; mode = md; limit = lm;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        @(posedge clk); #1 stop = 1'b0;
    endtask

    task automatic step_edges(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    // Edges until done is seen, or -1 when the budget runs out.
    task automatic wait_done(input int max_edges, output int k);
        k = -1;
        for (int i = 1; i <= max_edges; i++) begin
            @(posedge clk); #1;
            if (done) begin
                k = i;
                break;
            end
        end
    endtask

    int d;
    int p0;
    int rst_cnt;

    initial begin
        #2 clear = 1'b0;
        cmp_on = 1'b1;
        @(posedge clk); #1 clear = 1'b1;
        chk("reset_clr_n", int'(cnt_clr_n), 0);
        chk("reset_periods", int'(periods), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_busy", int'(busy), 0);
        @(posedge clk); #1;
        chk("post_reset_clr_n", int'(cnt_clr_n), 1);

        // One-shot, limit 5
        pulse_start(1'b0, 4'd5);
        chk("oneshot_arm_clr_n", int'(cnt_clr_n), 0);
        chk("oneshot_arm_busy", int'(busy), 1);
        wait_done(12, d);
        chk("oneshot_done_edge", d, 7);
        chk("oneshot_cnt_q", int'(cnt_q), 5);
        chk("oneshot_busy", int'(busy), 0);
        chk("oneshot_periods", int'(periods), 1);
        step_edges(3);
        chk("oneshot_hold_cnt_q", int'(cnt_q), 5);
        chk("oneshot_single_pulse", int'(periods), 1);

        // Periodic, limit 3
        do_reset();
        pulse_start(1'b1, 4'd3);
        for (int i = 0; i < 4; i++) begin
            wait_done(10, d);
            chk("periodic3_spacing", d, 5);
        end
        chk("periodic3_periods", int'(periods), 4);
        do_stop();
        chk("stop_busy", int'(busy), 0);

        // Pause for 3 cycles at cnt_q = 2, limit 6
        pulse_start(1'b0, 4'd6);
        step_edges(3);
        chk("pause_at_2", int'(cnt_q), 2);
        pause = 1'b1;
        step_edges(3);
        chk("pause_held_2", int'(cnt_q), 2);
        pause = 1'b0;
        wait_done(10, d);
        chk("pause_done_edge", 6 + d, 11);

        // limit 0 periodic, then limit 15 one-shot
        pulse_start(1'b1, 4'd0);
        for (int i = 0; i < 3; i++) begin
            wait_done(6, d);
            chk("limit0_spacing", d, 2);
        end
        pulse_start(1'b0, 4'd15);
        wait_done(20, d);
        chk("limit15_done_edge", d, 17);
        chk("limit15_cnt_q", int'(cnt_q), 15);

        // stop + start together in RUN
        pulse_start(1'b0, 4'd5);
        p0 = int'(periods);
        step_edges(2);
        stop = 1'b1; start = 1'b1;
        @(posedge clk); #1 stop = 1'b0; start = 1'b0;
        chk("stopstart_busy", int'(busy), 0);
        chk("stopstart_done", int'(done), 0);

        // start exactly at the terminal cycle
        pulse_start(1'b0, 4'd2);
        step_edges(3);
        chk("term_cnt_q", int'(cnt_q), 2);
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        chk("term_start_done", int'(done), 0);
        chk("term_start_clr_n", int'(cnt_clr_n), 0);
        chk("term_start_periods", int'(periods), p0);
        // stop exactly at the terminal cycle of the restarted interval
        step_edges(3);
        chk("term2_cnt_q", int'(cnt_q), 2);
        do_stop();
        chk("term_stop_done", int'(done), 0);
        chk("term_stop_busy", int'(busy), 0);
        chk("term_stop_periods", int'(periods), p0);

        // Async clear mid-run at cnt_q = 4
        pulse_start(1'b0, 4'd9);
        step_edges(5);
        chk("async_pre_cnt_q", int'(cnt_q), 4);
        #2 clear = 1'b0;
        #1;
        chk("async_busy", int'(busy), 0);
        chk("async_clr_n", int'(cnt_clr_n), 0);
        chk("async_periods", int'(periods), 0);
        chk("async_done", int'(done), 0);
        chk("async_cnt_q", int'(cnt_q), 0);
        @(posedge clk); #1 clear = 1'b1;
        pulse_start(1'b0, 4'd3);
        wait_done(10, d);
        chk("after_clear_done_edge", d, 5);

        // Tally wrap after 256 intervals
        do_reset();
        pulse_start(1'b1, 4'd0);
        for (int i = 0; i < 256; i++) begin
            wait_done(6, d);
            if (d < 0) chk("wrap_timeout", d, 2);
        end
        chk("wrap_periods", int'(periods), 0);
        do_stop();

        // Randomized traffic, checked cycle by cycle against the model
        rst_cnt = 0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            start = ($urandom_range(0, 11) == 0);
            stop  = ($urandom_range(0, 40) == 0);
            pause = ($urandom_range(0, 6) == 0);
            mode  = 1'($urandom_range(0, 1));
            limit = 4'($urandom_range(0, 15));
            if (rst_cnt > 0) begin
                rst_cnt--;
                if (rst_cnt == 0) clear = 1'b1;
            end else if ($urandom_range(0, 299) == 0) begin
                clear = 1'b0;
                rst_cnt = 2;
            end
        end
        @(posedge clk); #1;
        clear = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0;
        step_edges(2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
